// File: rtl/top_level.sv
// Single-car, 8-floor elevator controller: button synchronizers, request register,
// collective scheduling FSM and a 4-digit multiplexed seven-segment status display.
module top_level #(
    parameter int MOVE_CYCLES    = 50_000_000,
    parameter int DOOR_CYCLES    = 100_000_000,
    parameter int REFRESH_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       resetBtn,
    input  logic [5:0] sw_in,
    input  logic       button_up_in,
    input  logic       button_down_in,
    input  logic       button_in_in,
    output logic [6:0] seg_out,
    output logic [3:0] an_out,
    output logic       led0_out
);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

    state_t      r_state;
    logic [2:0]  r_floor;
    logic        r_dir;      // 1 = up
    logic [31:0] r_cnt;
    logic [7:0]  r_req;
    logic        r_led;
    logic [2:0]  r_sync1, r_sync2, r_prev;
    logic [31:0] r_ref_cnt;
    logic [1:0]  r_digit;

    logic [2:0]  w_pulse;
    logic [7:0]  w_req_set, w_clr;
    logic [2:0]  w_nf, w_low;
    logic        w_last_move, w_last_door;
    logic        w_up_cur, w_dn_cur, w_up_nf, w_dn_nf;

    function automatic logic any_above(input logic [7:0] r, input logic [2:0] f);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 8; i++)
            if (i > int'(f) && r[i]) a = 1'b1;
        return a;
    endfunction

    function automatic logic any_below(input logic [7:0] r, input logic [2:0] f);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 8; i++)
            if (i < int'(f) && r[i]) a = 1'b1;
        return a;
    endfunction

    function automatic logic [6:0] glyph(input logic [2:0] f);
        case (f)
            3'd0:    glyph = 7'b1000000;
            3'd1:    glyph = 7'b1111001;
            3'd2:    glyph = 7'b0100100;
            3'd3:    glyph = 7'b0110000;
            3'd4:    glyph = 7'b0011001;
            3'd5:    glyph = 7'b0010010;
            3'd6:    glyph = 7'b0000010;
            default: glyph = 7'b1111000;
        endcase
    endfunction

    // Bit order in the synchronizer chain: {up, down, in}.
    always_ff @(posedge clk or posedge resetBtn) begin
        if (resetBtn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= {button_up_in, button_down_in, button_in_in};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_pulse = r_sync2 & ~r_prev;

    always_comb begin
        w_req_set = '0;
        if (w_pulse[2] || w_pulse[1]) w_req_set = w_req_set | (8'b1 << sw_in[5:3]);
        if (w_pulse[0])               w_req_set = w_req_set | (8'b1 << sw_in[2:0]);
    end

    assign w_last_move = (r_cnt == 32'(MOVE_CYCLES - 1));
    assign w_last_door = (r_cnt == 32'(DOOR_CYCLES - 1));
    assign w_up_cur    = any_above(r_req, r_floor);
    assign w_dn_cur    = any_below(r_req, r_floor);
    assign w_up_nf     = any_above(r_req, w_nf);
    assign w_dn_nf     = any_below(r_req, w_nf);

    // Floor the car reaches at the end of the current move; clamped at 0 and 7.
    always_comb begin
        w_nf = r_floor;
        if (r_state == MOVE_UP && r_floor != 3'd7)   w_nf = r_floor + 3'd1;
        if (r_state == MOVE_DOWN && r_floor != 3'd0) w_nf = r_floor - 3'd1;
    end

    // The served floor is cleared on door entry and for the whole door period.
    always_comb begin
        w_clr = '0;
        if (r_state == DOOR || (r_state == IDLE && r_req[r_floor]))
            w_clr = 8'b1 << r_floor;
        else if ((r_state == MOVE_UP || r_state == MOVE_DOWN) && w_last_move && r_req[w_nf])
            w_clr = 8'b1 << w_nf;
    end

    always_ff @(posedge clk or posedge resetBtn) begin
        if (resetBtn) begin
            r_state <= IDLE;
            r_floor <= '0;
            r_dir   <= 1'b1;
            r_cnt   <= '0;
            r_req   <= '0;
            r_led   <= 1'b0;
        end else begin
            r_req <= (r_req | w_req_set) & ~w_clr;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (r_req[r_floor]) begin
                        r_state <= DOOR;
                        r_led   <= 1'b1;
                    end else if (w_up_cur) begin
                        r_state <= MOVE_UP;
                        r_dir   <= 1'b1;
                    end else if (w_dn_cur) begin
                        r_state <= MOVE_DOWN;
                        r_dir   <= 1'b0;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (w_last_move) begin
                        r_cnt   <= '0;
                        r_floor <= w_nf;
                        if (r_req[w_nf]) begin
                            r_state <= DOOR;
                            r_led   <= 1'b1;
                        end else if (r_dir ? w_up_nf : w_dn_nf) begin
                            r_state <= r_state;
                        end else if (r_dir ? w_dn_nf : w_up_nf) begin
                            r_state <= r_dir ? MOVE_DOWN : MOVE_UP;
                            r_dir   <= ~r_dir;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    if (w_last_door) begin
                        r_cnt <= '0;
                        r_led <= 1'b0;
                        if (r_dir ? w_up_cur : w_dn_cur) begin
                            r_state <= r_dir ? MOVE_UP : MOVE_DOWN;
                        end else if (r_dir ? w_dn_cur : w_up_cur) begin
                            r_state <= r_dir ? MOVE_DOWN : MOVE_UP;
                            r_dir   <= ~r_dir;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge resetBtn) begin
        if (resetBtn) begin
            r_ref_cnt <= '0;
            r_digit   <= '0;
        end else if (r_ref_cnt == 32'(REFRESH_CYCLES - 1)) begin
            r_ref_cnt <= '0;
            r_digit   <= r_digit + 2'd1;
        end else begin
            r_ref_cnt <= r_ref_cnt + 32'd1;
        end
    end

    always_comb begin
        w_low = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (r_req[i]) w_low = 3'(i);
    end

    always_comb begin
        seg_out = 7'b1111111;
        case (r_digit)
            2'd0: seg_out = glyph(r_floor);
            2'd1: seg_out = (r_state == MOVE_UP)   ? 7'b1000001 :
                            (r_state == MOVE_DOWN) ? 7'b0100001 : 7'b0111111;
            2'd2: seg_out = (|r_req) ? glyph(w_low) : 7'b1111111;
            default: seg_out = 7'b1111111;
        endcase
    end

    assign an_out   = ~(4'b0001 << r_digit);
    assign led0_out = r_led;

endmodule

// File: tb/tb_top_level.sv
// Scoreboard bench for the elevator controller: expected door-stop floors are queued
// with each request and checked against digit 0 whenever the door LED rises.
module tb_top_level;

    logic       clk = 1'b0;
    logic       resetBtn = 1'b0;
    logic [5:0] sw_in = '0;
    logic       button_up_in = 1'b0;
    logic       button_down_in = 1'b0;
    logic       button_in_in = 1'b0;
    logic [6:0] seg_out;
    logic [3:0] an_out;
    logic       led0_out;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_q[$];

    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_U     = 7'b1000001;
    localparam logic [6:0] G_3     = 7'b0110000;
    localparam logic [6:0] G_0     = 7'b1000000;

    top_level #(.MOVE_CYCLES(4), .DOOR_CYCLES(4), .REFRESH_CYCLES(2)) dut (
        .clk(clk), .resetBtn(resetBtn), .sw_in(sw_in),
        .button_up_in(button_up_in), .button_down_in(button_down_in),
        .button_in_in(button_in_in), .seg_out(seg_out), .an_out(an_out),
        .led0_out(led0_out)
    );

    always #5 clk = ~clk;

    function automatic int decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = 0;
            7'b1111001: decode = 1;
            7'b0100100: decode = 2;
            7'b0110000: decode = 3;
            7'b0011001: decode = 4;
            7'b0010010: decode = 5;
            7'b0000010: decode = 6;
            7'b1111000: decode = 7;
            default:    decode = -1;
        endcase
    endfunction

    // Door monitor: pops the expected floor on each door opening, checks door length.
    bit mon_pend = 0;
    bit prev_led = 0;
    int led_len  = 0;
    always @(negedge clk) begin
        if (resetBtn) begin
            mon_pend = 0; prev_led = 0; led_len = 0;
        end else begin
            if (led0_out && !prev_led) begin mon_pend = 1; led_len = 0; end
            if (led0_out) led_len++;
            if (!led0_out && prev_led) begin
                n_checks++;
                if (led_len != 4) begin
                    n_fails++;
                    $display("FAIL door_len: got %0d cycles, expected 4", led_len);
                end
            end
            if (mon_pend && an_out == 4'b1110) begin
                int exp_f, got_f;
                mon_pend = 0;
                n_checks++;
                got_f = decode(seg_out);
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL door_floor: unexpected door at floor %0d, none expected", got_f);
                end else begin
                    exp_f = exp_q.pop_front();
                    if (got_f !== exp_f) begin
                        n_fails++;
                        $display("FAIL door_floor: got %0d, expected %0d", got_f, exp_f);
                    end
                end
            end
            prev_led = led0_out;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk) resetBtn = 1'b1;
        repeat (2) @(negedge clk);
        resetBtn = 1'b0;
        exp_q.delete();
    endtask

    task automatic press(input bit up, input bit dn, input bit inn,
                         input logic [2:0] hall, input logic [2:0] car, input int hold);
        @(negedge clk);
        sw_in = {hall, car};
        button_up_in = up; button_down_in = dn; button_in_in = inn;
        repeat (hold) @(negedge clk);
        button_up_in = 1'b0; button_down_in = 1'b0; button_in_in = 1'b0;
    endtask

    task automatic wait_led(input int max, output int cyc, output bit ok);
        cyc = 0; ok = 0;
        while (cyc < max) begin
            @(posedge clk); #1;
            cyc++;
            if (led0_out) begin ok = 1; break; end
        end
    endtask

    task automatic wait_drain(input int max, output bit ok);
        int n;
        n = 0; ok = 0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (exp_q.size() == 0 && !mon_pend) begin ok = 1; break; end
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic read_digit(input int d, output logic [6:0] s, output bit ok);
        ok = 0; s = 'x;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (an_out == ~(4'b0001 << d)) begin s = seg_out; ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk) resetBtn = 1'b1;
        @(negedge clk);
        n_checks += 3;
        if (led0_out !== 1'b0)    begin n_fails++; $display("FAIL reset_led: got %b, expected 0", led0_out); end
        if (an_out !== 4'b1110)   begin n_fails++; $display("FAIL reset_an: got %b, expected 1110", an_out); end
        if (seg_out !== G_0)      begin n_fails++; $display("FAIL reset_seg: got %b, expected %b", seg_out, G_0); end
        resetBtn = 1'b0;
        #1;
        n_checks += 2;
        if (an_out !== 4'b1110)   begin n_fails++; $display("FAIL release_an: got %b, expected 1110", an_out); end
        if (seg_out !== G_0)      begin n_fails++; $display("FAIL release_seg: got %b, expected %b", seg_out, G_0); end
        exp_q.delete();
    endtask

    task automatic test_hall_up();
        int cyc; bit ok; logic [6:0] s;
        do_reset();
        exp_q.push_back(1);
        press(1, 0, 0, 3'd1, 3'd0, 2);
        wait_led(40, cyc, ok);
        n_checks++;
        if (!ok || cyc != 6) begin n_fails++; $display("FAIL hall_up_latency: got %0d (seen %b), expected 6", cyc, ok); end
        wait_drain(100, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL hall_up_drain: %0d stops left, expected 0", exp_q.size()); end
        read_digit(2, s, ok);
        n_checks++;
        if (s !== G_BLANK) begin n_fails++; $display("FAIL hall_up_req_clear: digit2 %b, expected %b", s, G_BLANK); end
        read_digit(1, s, ok);
        n_checks++;
        if (s !== G_DASH) begin n_fails++; $display("FAIL hall_up_idle: digit1 %b, expected %b", s, G_DASH); end
    endtask

    task automatic test_door_here();
        int cyc; bit ok;
        do_reset();
        exp_q.push_back(0);
        press(0, 0, 1, 3'd0, 3'd0, 2);
        wait_led(40, cyc, ok);
        n_checks++;
        if (!ok || cyc != 2) begin n_fails++; $display("FAIL door_here_latency: got %0d (seen %b), expected 2", cyc, ok); end
        wait_drain(100, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL door_here_drain: %0d stops left, expected 0", exp_q.size()); end
    endtask

    task automatic test_held_button();
        bit ok; logic [6:0] s;
        do_reset();
        exp_q.push_back(0);
        press(0, 0, 1, 3'd0, 3'd0, 25);
        wait_drain(100, ok);
        repeat (20) @(negedge clk);
        n_checks++;
        if (!ok || exp_q.size() != 0) begin n_fails++; $display("FAIL held_drain: %0d stops left, expected 0", exp_q.size()); end
        read_digit(2, s, ok);
        n_checks++;
        if (s !== G_BLANK) begin n_fails++; $display("FAIL held_no_repeat: digit2 %b, expected %b", s, G_BLANK); end
    endtask

    task automatic test_stop_on_way();
        bit ok; logic [6:0] d1, d2;
        do_reset();
        exp_q.push_back(3);
        exp_q.push_back(5);
        press(0, 0, 1, 3'd0, 3'd5, 2);
        press(0, 0, 1, 3'd0, 3'd3, 2);
        @(negedge clk);
        d1 = 'x; d2 = 'x;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (an_out == 4'b1101) d1 = seg_out;
            if (an_out == 4'b1011) d2 = seg_out;
        end
        n_checks += 2;
        if (d1 !== G_U) begin n_fails++; $display("FAIL way_motion: digit1 %b, expected %b", d1, G_U); end
        if (d2 !== G_3) begin n_fails++; $display("FAIL way_lowest: digit2 %b, expected %b", d2, G_3); end
        wait_drain(200, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL way_drain: %0d stops left, expected 0", exp_q.size()); end
    endtask

    task automatic test_reverse();
        int cyc; bit ok; logic [6:0] s;
        do_reset();
        exp_q.push_back(5);
        exp_q.push_back(7);
        exp_q.push_back(2);
        press(0, 0, 1, 3'd0, 3'd5, 2);
        wait_led(100, cyc, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL reverse_reach5: no door after %0d cycles, expected one", cyc); end
        press(0, 1, 1, 3'd2, 3'd7, 2);
        wait_drain(300, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL reverse_drain: %0d stops left, expected 0", exp_q.size()); end
        read_digit(0, s, ok);
        n_checks++;
        if (decode(s) != 2) begin n_fails++; $display("FAIL reverse_final_floor: got %0d, expected 2", decode(s)); end
    endtask

    task automatic test_reset_mid();
        bit ok; logic [6:0] s;
        do_reset();
        press(1, 0, 0, 3'd3, 3'd0, 2);
        repeat (5) @(negedge clk);
        resetBtn = 1'b1;
        #1;
        n_checks += 3;
        if (led0_out !== 1'b0)  begin n_fails++; $display("FAIL mid_reset_led: got %b, expected 0", led0_out); end
        if (an_out !== 4'b1110) begin n_fails++; $display("FAIL mid_reset_an: got %b, expected 1110", an_out); end
        if (seg_out !== G_0)    begin n_fails++; $display("FAIL mid_reset_seg: got %b, expected %b", seg_out, G_0); end
        @(negedge clk);
        resetBtn = 1'b0;
        exp_q.delete();
        repeat (40) @(negedge clk);
        read_digit(2, s, ok);
        n_checks++;
        if (s !== G_BLANK) begin n_fails++; $display("FAIL mid_reset_req: digit2 %b, expected %b", s, G_BLANK); end
        read_digit(0, s, ok);
        n_checks++;
        if (s !== G_0) begin n_fails++; $display("FAIL mid_reset_floor: digit0 %b, expected %b", s, G_0); end
    endtask

    initial begin
        test_reset();
        test_hall_up();
        test_door_here();
        test_held_button();
        test_stop_on_way();
        test_reverse();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
